// File: rtl/scan_chain_pkg.sv
// Shared state encoding and sizing helper for the scan chain controller.
package scan_chain_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } scan_state_t;

  // Smallest w with 2**w >= n; usable in constant expressions.
  function automatic int unsigned ceil_log2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/scan_step_div.sv
// Shift-rate prescaler: registered one-cycle step strobe once every DIV running cycles.
module scan_step_div #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  input  logic run_next,
  output logic step
);
  import scan_chain_pkg::*;

  localparam int unsigned   CNT_W = ceil_log2(DIV) + 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Strobe is looked ahead one cycle so it is a flop yet aligned with cnt == DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      step  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      step  <= run_next && (cnt_d == TERM);
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shifts a host pattern into an external scan register MSB first while
// collecting the register's previous contents. Define SCAN_CAPTURE_EN for a functional capture cycle.
module scan_chain_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic             result_valid,
  output logic             sr_enable,
  output logic             sr_scan_enable,
  output logic             sr_scan_in,
  input  logic             sr_scan_out
);
  import scan_chain_pkg::*;

  localparam int unsigned BIT_CNT_W = ceil_log2(WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

`ifdef SCAN_CAPTURE_EN
  localparam scan_state_t FIRST_STATE = CAPTURE;
`else
  localparam scan_state_t FIRST_STATE = SHIFT;
`endif

  scan_state_t          state_q;
  scan_state_t          state_d;
  logic [WIDTH-1:0]     pat_q;
  logic [WIDTH-1:0]     pat_d;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     result_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_d;
  logic [WIDTH-1:0]     result_out_d;
  logic                 result_valid_d;
  logic                 div_clr;

  // sr_scan_enable doubles as the internal step strobe.
  scan_step_div #(
    .DIV (DIV)
  ) u_step_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (div_clr),
    .run      (state_q == SHIFT),
    .run_next (state_d == SHIFT),
    .step     (sr_scan_enable)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d        = state_q;
    pat_d          = pat_q;
    result_d       = result_q;
    bit_cnt_d      = bit_cnt_q;
    result_out_d   = result_out;
    result_valid_d = result_valid;
    div_clr        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pat_d          = pattern_in;
          result_valid_d = 1'b0;
          bit_cnt_d      = '0;
          div_clr        = 1'b1;
          state_d        = FIRST_STATE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          div_clr = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          div_clr   = 1'b1;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (sr_scan_enable) begin
          // scan_out is sampled here, before the register moves on this edge.
          pat_d    = pat_q << 1;
          result_d = {result_q[WIDTH-2:0], sr_scan_out};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d      = '0;
            result_out_d   = result_d;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pat_q        <= '0;
      result_q     <= '0;
      bit_cnt_q    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
      sr_scan_in   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      result_q     <= result_d;
      bit_cnt_q    <= bit_cnt_d;
      busy         <= (state_d != IDLE);
      done         <= (state_d == DONE);
      result_out   <= result_out_d;
      result_valid <= result_valid_d;
      sr_scan_in   <= (state_d == SHIFT) & pat_d[WIDTH-1];
    end
  end

`ifdef SCAN_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_enable <= 1'b0;
    end else begin
      sr_enable <= (state_d == CAPTURE);
    end
  end
`else
  assign sr_enable = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: a DIV=1 and a DIV=3 controller, each driving a behavioural scan
// register, checked every cycle against a timeline model; follows SCAN_CAPTURE_EN.
module tb_scan_chain_ctrl;

  localparam int W = 8;
`ifdef SCAN_CAPTURE_EN
  localparam int CAP = 1;
  localparam logic [W-1:0] EXP_R0 = 8'h5A;
  localparam logic [W-1:0] EXP_R1 = 8'h5A;
`else
  localparam int CAP = 0;
  localparam logic [W-1:0] EXP_R0 = 8'hA5;
  localparam logic [W-1:0] EXP_R1 = 8'h69;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start [2];
  logic         abort [2];
  logic [W-1:0] pattern_in [2];
  logic         busy [2];
  logic         done [2];
  logic [W-1:0] result_out [2];
  logic         result_valid [2];
  logic         sr_enable [2];
  logic         sr_scan_enable [2];
  logic         sr_scan_in [2];

  // Behavioural scan register environment.
  logic [W-1:0] chain [2];
  logic [W-1:0] data_in [2];
  logic [W-1:0] pre_val [2];
  logic         pre_en [2];

  // Model: n = cycles since the accepted start edge (0 = idle).
  int           n [2] = '{0, 0};
  logic [W-1:0] m_pat [2];
  logic [W-1:0] m_res [2];
  logic         m_rv [2] = '{1'b0, 1'b0};

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.WIDTH(W), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .pattern_in(pattern_in[0]),
    .busy(busy[0]), .done(done[0]), .result_out(result_out[0]), .result_valid(result_valid[0]),
    .sr_enable(sr_enable[0]), .sr_scan_enable(sr_scan_enable[0]), .sr_scan_in(sr_scan_in[0]),
    .sr_scan_out(chain[0][W-1])
  );

  scan_chain_ctrl #(.WIDTH(W), .DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .pattern_in(pattern_in[1]),
    .busy(busy[1]), .done(done[1]), .result_out(result_out[1]), .result_valid(result_valid[1]),
    .sr_enable(sr_enable[1]), .sr_scan_enable(sr_scan_enable[1]), .sr_scan_in(sr_scan_in[1]),
    .sr_scan_out(chain[1][W-1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int len_of(input int i);
    return CAP + W * div_of(i) + 1;
  endfunction

  task automatic check(input string name, input int i, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (dut%0d) at %0t: got %h, expected %h", name, i, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pre_en[i])              chain[i] <= pre_val[i];
      else if (sr_enable[i])      chain[i] <= data_in[i];
      else if (sr_scan_enable[i]) chain[i] <= {chain[i][W-2:0], sr_scan_in[i]};
    end
  end

  // Transaction timeline model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        n[i]    = 0;
        m_rv[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (n[i] == 0) begin
          if (start[i]) begin
            n[i]     = 1;
            m_pat[i] = pattern_in[i];
            m_res[i] = (CAP != 0) ? data_in[i] : chain[i];
            m_rv[i]  = 1'b0;
          end
        end else if (n[i] == len_of(i) || abort[i]) begin
          n[i] = 0;
        end else begin
          n[i] = n[i] + 1;
          if (n[i] == len_of(i)) m_rv[i] = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   k;
      int   d;
      logic e_se;
      logic e_si;
      k    = n[i];
      d    = div_of(i);
      e_se = 1'b0;
      e_si = 1'b0;
      if (k > CAP && k <= CAP + W * d) begin
        e_se = ((k - CAP) % d) == 0;
        e_si = m_pat[i][W - 1 - (k - CAP - 1) / d];
      end
      check("busy", i, W'(busy[i]), W'(k >= 1));
      check("done", i, W'(done[i]), W'(k == len_of(i)));
      check("sr_enable", i, W'(sr_enable[i]), W'(CAP == 1 && k == 1));
      check("sr_scan_enable", i, W'(sr_scan_enable[i]), W'(e_se));
      check("sr_scan_in", i, W'(sr_scan_in[i]), W'(e_si));
      check("result_valid", i, W'(result_valid[i]), W'(m_rv[i]));
      if (m_rv[i]) check("result_out", i, result_out[i], m_res[i]);
      if (k == len_of(i)) check("chain_after_shift", i, chain[i], m_pat[i]);
    end
  end

  task automatic run_op(input int i, input logic [W-1:0] pat, output int lat,
                        output int se_cnt, output int en_cnt, output bit gap_ok);
    int last;
    @(negedge clk);
    start[i] = 1'b1;
    pattern_in[i] = pat;
    @(negedge clk);
    start[i] = 1'b0;
    lat = 0; se_cnt = 0; en_cnt = 0; gap_ok = 1'b1; last = 0;
    for (int c = 1; c <= 200; c++) begin
      if (sr_enable[i]) en_cnt++;
      if (sr_scan_enable[i]) begin
        if (se_cnt > 0 && c - last != div_of(i)) gap_ok = 1'b0;
        se_cnt++;
        last = c;
      end
      if (done[i]) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_quiet(input int i, input string tag);
    check({tag, "_busy"}, i, W'(busy[i]), W'(1'b0));
    check({tag, "_done"}, i, W'(done[i]), W'(1'b0));
    check({tag, "_valid"}, i, W'(result_valid[i]), W'(1'b0));
    check({tag, "_scan_en"}, i, W'(sr_scan_enable[i]), W'(1'b0));
    check({tag, "_scan_in"}, i, W'(sr_scan_in[i]), W'(1'b0));
    check({tag, "_enable"}, i, W'(sr_enable[i]), W'(1'b0));
    check({tag, "_result"}, i, result_out[i], W'(0));
  endtask

  initial begin
    int lat, se_cnt, en_cnt, dones, steps;
    bit gap_ok;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; pattern_in[i] = '0;
      pre_en[i] = 1'b0; pre_val[i] = '0; data_in[i] = 8'h5A;
    end
    repeat (3) @(negedge clk);
    check_quiet(0, "reset");
    check_quiet(1, "reset");
    rst_n = 1'b1;

    @(negedge clk);
    pre_en[0] = 1'b1; pre_val[0] = 8'hA5;
    pre_en[1] = 1'b1; pre_val[1] = 8'h69;
    @(negedge clk);
    pre_en[0] = 1'b0; pre_en[1] = 1'b0;

    // DIV=1 pattern 3C over preload A5.
    run_op(0, 8'h3C, lat, se_cnt, en_cnt, gap_ok);
    check("latency_div1", 0, W'(lat), W'(9 + CAP));
    check("result_first", 0, result_out[0], EXP_R0);
    check("valid_first", 0, W'(result_valid[0]), W'(1'b1));
    check("chain_first", 0, chain[0], 8'h3C);
    check("steps_div1", 0, W'(se_cnt), W'(8));
    check("capture_cycles", 0, W'(en_cnt), W'(CAP));

    // DIV=3: 25 cycles, eight steps spaced 3 apart.
    run_op(1, 8'hE1, lat, se_cnt, en_cnt, gap_ok);
    check("latency_div3", 1, W'(lat), W'(25 + CAP));
    check("steps_div3", 1, W'(se_cnt), W'(8));
    check("step_spacing", 1, W'(gap_ok), W'(1'b1));
    check("result_div3", 1, result_out[1], EXP_R1);
    check("chain_div3", 1, chain[1], 8'hE1);

    // Start while busy is dropped.
    @(negedge clk);
    start[0] = 1'b1; pattern_in[0] = 8'hC3;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    start[0] = 1'b1; pattern_in[0] = 8'h81;
    @(negedge clk);
    start[0] = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done[0]) dones++;
      @(negedge clk);
    end
    check("busy_start_dones", 0, W'(dones), W'(1));
    check("busy_start_chain", 0, chain[0], 8'hC3);

    // Abort on the fourth step.
    @(negedge clk);
    start[0] = 1'b1; pattern_in[0] = 8'h96;
    @(negedge clk);
    start[0] = 1'b0;
    steps = 0;
    for (int c = 0; c < 100; c++) begin
      if (sr_scan_enable[0]) steps++;
      if (steps == 4) break;
      @(negedge clk);
    end
    check("abort_reached_step4", 0, W'(steps), W'(4));
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort_busy", 0, W'(busy[0]), W'(1'b0));
    check("abort_scan_en", 0, W'(sr_scan_enable[0]), W'(1'b0));
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done[0]) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 0, W'(dones), W'(0));
    check("abort_valid", 0, W'(result_valid[0]), W'(1'b0));
    run_op(0, 8'h4B, lat, se_cnt, en_cnt, gap_ok);
    check("after_abort_latency", 0, W'(lat), W'(9 + CAP));
    check("after_abort_chain", 0, chain[0], 8'h4B);

    // Asynchronous reset mid-shift.
    @(negedge clk);
    start[0] = 1'b1; pattern_in[0] = 8'h0F;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet(0, "midreset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic on both controllers.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        start[i] = 1'b0; abort[i] = 1'b0; pre_en[i] = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          start[i] = 1'b1;
          pattern_in[i] = W'($urandom);
        end
        if ($urandom_range(0, 39) == 0) abort[i] = 1'b1;
        if (n[i] == 0 && !start[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pre_en[i] = 1'b1;
            pre_val[i] = W'($urandom);
          end
          if ($urandom_range(0, 3) == 0) data_in[i] = W'($urandom);
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; pre_en[i] = 1'b0;
    end
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
